// File: rtl/cam_power_seq_if.sv
// Control inputs, camera pin drives and status of the OV5640 power sequencer.
// master = the sequencer itself, slave = board/config side that drives it.
interface cam_power_seq_if;
  logic       en;
  logic       restart;
  logic       cfg_done;
  logic       cam_pwdn;
  logic       cam_rst_n;
  logic       xclk_en;
  logic       power_done;
  logic       cfg_start;
  logic       fault;
  logic [2:0] state;

  modport master (
    input  en, restart, cfg_done,
    output cam_pwdn, cam_rst_n, xclk_en, power_done, cfg_start, fault, state
  );

  modport slave (
    output en, restart, cfg_done,
    input  cam_pwdn, cam_rst_n, xclk_en, power_done, cfg_start, fault, state
  );
endinterface

// File: rtl/cam_power_seq.sv
// OV5640 power-up/power-down sequencer: timed PWDN/RESET_N/XCLK release,
// SCCB configuration kick-off with timeout, bounded retry and fault latch.
module cam_power_seq #(
  parameter int T_PWDN    = 300_000,
  parameter int T_RST     = 100_000,
  parameter int T_SETTLE  = 1_050_000,
  parameter int T_CFG_TO  = 5_000_000,
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 23
) (
  input logic              sys_clk,
  input logic              sys_rst_n,
  cam_power_seq_if.master  bus
);

  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0]   LAST_PWDN   = CNT_W'(T_PWDN - 1);
  localparam logic [CNT_W-1:0]   LAST_RST    = CNT_W'(T_RST - 1);
  localparam logic [CNT_W-1:0]   LAST_SETTLE = CNT_W'(T_SETTLE - 1);
  localparam logic [CNT_W-1:0]   LAST_CFG    = CNT_W'(T_CFG_TO - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    OFF       = 3'd0,
    PWDN_HOLD = 3'd1,
    RST_HOLD  = 3'd2,
    SETTLE    = 3'd3,
    CONFIG    = 3'd4,
    ACTIVE    = 3'd5,
    SHUTDOWN  = 3'd6,
    FAULT     = 3'd7
  } state_t;

  state_t             cur;
  state_t             nxt;
  logic [CNT_W-1:0]   cnt;
  logic [RETRY_W-1:0] retry;
  logic [RETRY_W-1:0] retry_nxt;

  // Pin pattern per state as {cam_pwdn, cam_rst_n, xclk_en, power_done}.
  function automatic logic [3:0] pins(input state_t s);
    case (s)
      PWDN_HOLD: pins = 4'b1010;
      RST_HOLD:  pins = 4'b0010;
      SETTLE:    pins = 4'b0110;
      CONFIG:    pins = 4'b0111;
      ACTIVE:    pins = 4'b0111;
      SHUTDOWN:  pins = 4'b1010;
      default:   pins = 4'b1000;
    endcase
  endfunction

  // Priority inside every state: en low, then restart, then cfg_done, then timer.
  always_comb begin
    nxt       = cur;
    retry_nxt = retry;
    case (cur)
      OFF:       if (bus.en) nxt = PWDN_HOLD;
      PWDN_HOLD: begin
        if (!bus.en)                nxt = OFF;
        else if (cnt == LAST_PWDN)  nxt = RST_HOLD;
      end
      RST_HOLD: begin
        if (!bus.en)                nxt = SHUTDOWN;
        else if (cnt == LAST_RST)   nxt = SETTLE;
      end
      SETTLE: begin
        if (!bus.en)                nxt = SHUTDOWN;
        else if (cnt == LAST_SETTLE) nxt = CONFIG;
      end
      CONFIG: begin
        if (!bus.en) begin
          nxt = SHUTDOWN;
        end else if (bus.restart) begin
          nxt       = SHUTDOWN;
          retry_nxt = '0;
        end else if (bus.cfg_done) begin
          nxt = ACTIVE;
        end else if (cnt == LAST_CFG) begin
          if (retry < RETRY_MAX) begin
            nxt       = SHUTDOWN;
            retry_nxt = retry + 1'b1;
          end else begin
            nxt = FAULT;
          end
        end
      end
      ACTIVE: begin
        if (!bus.en) begin
          nxt = SHUTDOWN;
        end else if (bus.restart) begin
          nxt       = SHUTDOWN;
          retry_nxt = '0;
        end
      end
      SHUTDOWN:  if (cnt == LAST_RST) nxt = bus.en ? PWDN_HOLD : OFF;
      FAULT: begin
        if (!bus.en) begin
          nxt = OFF;
        end else if (bus.restart) begin
          nxt       = PWDN_HOLD;
          retry_nxt = '0;
        end
      end
      default:   nxt = OFF;
    endcase
    if (nxt == OFF || nxt == ACTIVE) retry_nxt = '0;
  end

  // Outputs are decoded from the next state so pins move on the same edge as state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cur            <= OFF;
      cnt            <= '0;
      retry          <= '0;
      bus.cam_pwdn   <= 1'b1;
      bus.cam_rst_n  <= 1'b0;
      bus.xclk_en    <= 1'b0;
      bus.power_done <= 1'b0;
      bus.cfg_start  <= 1'b0;
      bus.fault      <= 1'b0;
    end else begin
      cur   <= nxt;
      retry <= retry_nxt;
      if (nxt != cur || cur == OFF || cur == ACTIVE || cur == FAULT)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      {bus.cam_pwdn, bus.cam_rst_n, bus.xclk_en, bus.power_done} <= pins(nxt);
      bus.cfg_start <= (nxt == CONFIG) && (cur != CONFIG);
      bus.fault     <= (nxt == FAULT);
    end
  end

  assign bus.state = cur;

endmodule

// File: tb/tb_cam_power_seq.sv
// Bench for cam_power_seq: directed scenarios with literal expectations plus
// randomized traffic, all cross-checked every cycle against a phase/countdown model.
module tb_cam_power_seq;
  localparam int TP = 6, TR = 4, TS = 8, TC = 10, MR = 1;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  cam_power_seq_if bus();

  cam_power_seq #(
    .T_PWDN(TP), .T_RST(TR), .T_SETTLE(TS), .T_CFG_TO(TC),
    .MAX_RETRY(MR), .CNT_W(8)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_starts = 0;

  // Model: phase number, cycles left in that phase, retries used.
  int   m_ph    = 0;
  int   m_rem   = 0;
  int   m_tries = 0;
  logic m_start = 1'b0;
  int   dur [8] = '{0, TP, TR, TS, TC, 0, TR, 0};
  // {cam_pwdn, cam_rst_n, xclk_en, power_done} per phase
  logic [3:0] pin_tab [8] = '{4'b1000, 4'b1010, 4'b0010, 4'b0110,
                              4'b0111, 4'b0111, 4'b1010, 4'b1000};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_ph = 0; m_rem = 0; m_tries = 0; m_start = 1'b0;
  endtask

  task automatic m_go(input int p);
    m_ph    = p;
    m_rem   = dur[p];
    m_start = (p == 4);
    if (p == 0 || p == 5) m_tries = 0;
  endtask

  task automatic m_step(input logic en, input logic rs, input logic cd);
    int   p0;
    logic last;
    p0      = m_ph;
    last    = (m_rem == 1);
    m_start = 1'b0;
    case (p0)
      0: if (en) m_go(1);
      1: if (!en) m_go(0); else if (last) m_go(2);
      2: if (!en) m_go(6); else if (last) m_go(3);
      3: if (!en) m_go(6); else if (last) m_go(4);
      4: begin
        if (!en) m_go(6);
        else if (rs) begin m_tries = 0; m_go(6); end
        else if (cd) m_go(5);
        else if (last) begin
          if (m_tries < MR) begin m_tries++; m_go(6); end
          else m_go(7);
        end
      end
      5: if (!en) m_go(6); else if (rs) begin m_tries = 0; m_go(6); end
      6: if (last) m_go(en ? 1 : 0);
      7: if (!en) m_go(0); else if (rs) begin m_tries = 0; m_go(1); end
      default: m_go(0);
    endcase
    if (m_ph == p0) m_rem--;
  endtask

  initial begin
    forever begin
      @(posedge sys_clk or negedge sys_rst_n);
      if (!sys_rst_n) m_reset();
      else m_step(bus.en, bus.restart, bus.cfg_done);
    end
  end

  initial begin
    forever begin
      @(negedge sys_clk);
      chk("m_state",      bus.state,      m_ph);
      chk("m_cam_pwdn",   bus.cam_pwdn,   pin_tab[m_ph][3]);
      chk("m_cam_rst_n",  bus.cam_rst_n,  pin_tab[m_ph][2]);
      chk("m_xclk_en",    bus.xclk_en,    pin_tab[m_ph][1]);
      chk("m_power_done", bus.power_done, pin_tab[m_ph][0]);
      chk("m_cfg_start",  bus.cfg_start,  m_start);
      chk("m_fault",      bus.fault,      (m_ph == 7));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge sys_clk);
    #2;
    if (bus.cfg_start === 1'b1) n_starts++;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
    for (int i = 0; i < budget && bus.state !== s; i++) cyc();
    chk(nm, bus.state, s);
  endtask

  initial begin
    bus.en = 1'b0; bus.restart = 1'b0; bus.cfg_done = 1'b0;
    repeat (3) cyc();
    chk("rst_state",      bus.state,      0);
    chk("rst_cam_pwdn",   bus.cam_pwdn,   1);
    chk("rst_cam_rst_n",  bus.cam_rst_n,  0);
    chk("rst_xclk_en",    bus.xclk_en,    0);
    chk("rst_power_done", bus.power_done, 0);
    chk("rst_fault",      bus.fault,      0);
    sys_rst_n = 1'b1;
    cyc();

    // Nominal power-up, edge 0 is the edge that samples en=1.
    bus.en = 1'b1;
    n_starts = 0;
    cyc();                                  // edge 0
    chk("nom_e0_state", bus.state, 1);
    chk("nom_e0_xclk",  bus.xclk_en, 1);
    repeat (5) cyc();                       // edge 5
    chk("nom_e5_pwdn", bus.cam_pwdn, 1);
    cyc();                                  // edge 6
    chk("nom_e6_pwdn",  bus.cam_pwdn, 0);
    chk("nom_e6_state", bus.state, 2);
    repeat (3) cyc();                       // edge 9
    chk("nom_e9_rst_n", bus.cam_rst_n, 0);
    cyc();                                  // edge 10
    chk("nom_e10_rst_n", bus.cam_rst_n, 1);
    repeat (7) cyc();                       // edge 17
    chk("nom_e17_pdone", bus.power_done, 0);
    cyc();                                  // edge 18
    chk("nom_e18_pdone", bus.power_done, 1);
    chk("nom_e18_start", bus.cfg_start, 1);
    chk("nom_e18_state", bus.state, 4);
    cyc();                                  // edge 19
    chk("nom_e19_start", bus.cfg_start, 0);
    repeat (5) cyc();                       // edge 24
    chk("nom_e24_state", bus.state, 4);
    bus.cfg_done = 1'b1;
    cyc();                                  // edge 25
    chk("nom_e25_state", bus.state, 5);
    chk("nom_starts", n_starts, 1);

    // Timeout, one retry, then FAULT.
    bus.en = 1'b0; bus.cfg_done = 1'b0;
    wait_state(3'd0, 20, "to_off");
    n_starts = 0;
    bus.en = 1'b1;
    wait_state(3'd7, 200, "to_fault");
    chk("to_starts",     n_starts, 2);
    chk("to_fault_flag", bus.fault, 1);
    chk("to_fault_xclk", bus.xclk_en, 0);
    chk("to_fault_pwdn", bus.cam_pwdn, 1);

    // FAULT recovery via restart, then via en=0.
    bus.restart = 1'b1;
    cyc();
    bus.restart = 1'b0;
    chk("rec_state", bus.state, 1);
    chk("rec_fault", bus.fault, 0);
    wait_state(3'd7, 200, "rec_fault_again");
    bus.en = 1'b0;
    cyc();
    chk("rec_off", bus.state, 0);

    // Enable drop in PWDN_HOLD and in ACTIVE.
    bus.en = 1'b1;
    cyc(); cyc();
    chk("drop_pwdn_hold", bus.state, 1);
    bus.en = 1'b0;
    cyc();
    chk("drop_to_off", bus.state, 0);
    bus.en = 1'b1; bus.cfg_done = 1'b1;
    wait_state(3'd5, 100, "drop_active");
    bus.en = 1'b0;
    cyc();
    chk("drop_sd_state", bus.state, 6);
    chk("drop_sd_rst_n", bus.cam_rst_n, 0);
    chk("drop_sd_pwdn",  bus.cam_pwdn, 1);
    chk("drop_sd_pdone", bus.power_done, 0);
    repeat (TR - 1) cyc();
    chk("drop_sd_last", bus.state, 6);
    cyc();
    chk("drop_sd_off", bus.state, 0);

    // cfg_done on the timeout cycle wins.
    bus.cfg_done = 1'b0; bus.en = 1'b1;
    wait_state(3'd4, 100, "sim_config");
    repeat (TC - 1) cyc();
    bus.cfg_done = 1'b1;
    cyc();
    chk("sim_cd_at_timeout", bus.state, 5);

    // restart together with en=0 in ACTIVE: shutdown ends in OFF.
    bus.restart = 1'b1; bus.en = 1'b0;
    cyc();
    bus.restart = 1'b0;
    chk("sim_rs_en0_sd", bus.state, 6);
    repeat (TR - 1) cyc();
    chk("sim_rs_en0_hold", bus.state, 6);
    cyc();
    chk("sim_rs_en0_off", bus.state, 0);

    // Asynchronous reset mid-SETTLE.
    bus.cfg_done = 1'b0; bus.en = 1'b1;
    wait_state(3'd3, 100, "ar_settle");
    cyc();
    #1 sys_rst_n = 1'b0;
    #1;
    chk("ar_state",      bus.state,      0);
    chk("ar_cam_pwdn",   bus.cam_pwdn,   1);
    chk("ar_cam_rst_n",  bus.cam_rst_n,  0);
    chk("ar_xclk_en",    bus.xclk_en,    0);
    chk("ar_power_done", bus.power_done, 0);
    chk("ar_cfg_start",  bus.cfg_start,  0);
    chk("ar_fault",      bus.fault,      0);
    cyc();
    sys_rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if (bus.en) bus.en = ($urandom_range(0, 99) < 97);
      else        bus.en = ($urandom_range(0, 9) < 3);
      bus.restart  = ($urandom_range(0, 39) == 0);
      bus.cfg_done = ($urandom_range(0, 7) == 0);
      if (i == 2000) begin
        #1 sys_rst_n = 1'b0;
        cyc();
        sys_rst_n = 1'b1;
      end
      cyc();
    end

    bus.en = 1'b0; bus.restart = 1'b0; bus.cfg_done = 1'b0;
    repeat (2) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
